vx_stream_fifo: RTL and testbench
=================================

VX_STREAM_FIFO -- requirements
Module: VX_stream_fifo

Interface
REQ-001 SHALL have parameter DATAW, default 1: payload width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 4: entry count, power of two, minimum 2.
REQ-003 SHALL have parameter ALM_FULL, default DEPTH-1: occupancy threshold for alm_full, range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port valid_in, input, 1: upstream push request.
REQ-007 SHALL have port ready_in, output, 1: FIFO accepts a push this cycle.
REQ-008 SHALL have port data_in, input, DATAW: push payload.
REQ-009 SHALL have port valid_out, output, 1: head entry available.
REQ-010 SHALL have port ready_out, input, 1: downstream pop acknowledge; feeds a coupled-ready pipe buffer.
REQ-011 SHALL have port data_out, output, DATAW: head entry payload.
REQ-012 SHALL have port count, output, log2(DEPTH)+1: current occupancy.
REQ-013 SHALL have port alm_full, output, 1: count >= ALM_FULL.

Function
REQ-014 push SHALL occur when valid_in && ready_in; pop SHALL occur when valid_out && ready_out.
REQ-015 ready_in SHALL be ~full, driven from a register with no combinational path from ready_out, which breaks the ready chain of the downstream buffer.
REQ-016 valid_out SHALL be ~empty, driven from a register with no combinational path from valid_in.
REQ-017 Latency: a push into an empty FIFO at edge N SHALL give valid_out=1 with that data after edge N; there is no same-cycle passthrough.
REQ-018 data_out SHALL equal the entry at the read pointer and SHALL stay stable while valid_out && ~ready_out.
REQ-019 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH with no gap entry; all DEPTH entries SHALL be usable.
REQ-020 count update: push only +1, pop only -1, push and pop together or neither unchanged.
REQ-021 full SHALL be next-count==DEPTH and empty SHALL be next-count==0, both registered.
REQ-022 Simultaneous push and pop when count==1 SHALL keep valid_out=1 and present the new entry after the edge.
REQ-023 Simultaneous push and pop at count==DEPTH SHALL NOT occur, because ready_in=0; a pop at full SHALL give ready_in=1 in the next cycle.
REQ-024 When valid_in=1 and ready_in=0, the input SHALL be ignored and no state SHALL change.
REQ-025 alm_full SHALL be registered and consistent with the count of the same cycle.
REQ-026 The order of pops SHALL equal the order of pushes, with no loss or duplication.

Reset
REQ-027 While reset=1 (asynchronously): pointers=0, count=0, valid_out=0, ready_in=1, alm_full=0 (1 if ALM_FULL==0 is ever permitted; excluded by REQ-003).
REQ-028 Storage contents SHALL NOT be reset; data_out is don't-care while valid_out=0.
REQ-029 Reset mid-operation SHALL discard all entries; the first push after deassertion SHALL be the first popped.
REQ-030 No push or pop SHALL be taken on the edge where reset is asserted.

Structure
REQ-031 No package typedefs are needed; the log2 / clog2 helper SHALL come from the shared platform define header, not be redefined locally.
REQ-032 Storage SHALL be one sub-module VX_fifo_mem (DATAW x DEPTH, one write port, one asynchronous read port, no reset).
REQ-033 The pointer, count and flag logic SHALL live in VX_stream_fifo; target size is 150-250 lines total.

Verification
REQ-034 Reset, then push 0xA,0xB,0xC,0xD with DATAW=8, DEPTH=4, ready_out=0 -> ready_in=0 after the 4th push, count=4, alm_full=1 from count=3.
REQ-035 Full FIFO, then ready_out=1 for 4 cycles -> data_out 0xA,0xB,0xC,0xD in order, valid_out=0 after the last pop, ready_in=1 one cycle after the first pop.
REQ-036 count=1 (head 0x11), push 0x22 and pop in the same cycle -> count stays 1, data_out=0x22 next cycle.
REQ-037 Continuous valid_in=1 and ready_out=1 for 20 cycles, data 0..19 -> after 1 cycle of latency, one pop per cycle, 0..19 in order, count constant at 1.
REQ-038 Push 3 entries, assert reset asynchronously mid-cycle -> valid_out=0, count=0, ready_in=1 immediately; after deassertion, push 0x55 -> first pop is 0x55.
REQ-039 Random valid_in/ready_out at 50% for 10k cycles against a scoreboard -> no ordering error, count always 0..DEPTH, no push while ready_in=0.

Source files
------------

// File: rtl/vx_stream_fifo_pkg.sv
// rtl/vx_stream_fifo_pkg.sv - shared types for the stream FIFO
// Encodes the per-cycle push/pop combination that drives the occupancy update.
package vx_stream_fifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/vx_stream_fifo_mem.sv
// rtl/vx_stream_fifo_mem.sv - DATAW x DEPTH storage, one write port, async read
// Contents are deliberately left unreset; readers qualify data with valid.
module vx_stream_fifo_mem #(
  parameter int DATAW = 1,
  parameter int DEPTH = 4,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [DATAW-1:0] wr_data,
  input  logic [ADDRW-1:0] rd_addr,
  output logic [DATAW-1:0] rd_data
);

  logic [DATAW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/vx_stream_fifo.sv
// rtl/vx_stream_fifo.sv - valid/ready stream FIFO with registered handshake flags
// ready_in and valid_out come straight from flops so neither side sees a combinational path.
module vx_stream_fifo
  import vx_stream_fifo_pkg::*;
#(
  parameter int DATAW    = 1,
  parameter int DEPTH    = 4,
  parameter int ALM_FULL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [DATAW-1:0]           data_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [DATAW-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       alm_full
);

  localparam int ADDRW = $clog2(DEPTH);
  localparam int CNTW  = ADDRW + 1;

  logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             ready_in_q, ready_in_d;
  logic             valid_out_q, valid_out_d;
  logic             alm_full_q, alm_full_d;
  logic             push, pop;
  fifo_op_e         op;

  assign push = valid_in & ready_in_q;
  assign pop  = valid_out_q & ready_out;

  always_comb begin
    op          = fifo_op_e'({push, pop});
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDRW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDRW'(1);
    case (op)
      OP_PUSH: count_d = count_q + CNTW'(1);
      OP_POP:  count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    // Flags follow the next occupancy so they are correct in the same cycle as count.
    ready_in_d  = (count_d != CNTW'(DEPTH));
    valid_out_d = (count_d != CNTW'(0));
    alm_full_d  = (count_d >= CNTW'(ALM_FULL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_in_q  <= 1'b1;
      valid_out_q <= 1'b0;
      alm_full_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_in_q  <= ready_in_d;
      valid_out_q <= valid_out_d;
      alm_full_q  <= alm_full_d;
    end
  end

  vx_stream_fifo_mem #(
    .DATAW (DATAW),
    .DEPTH (DEPTH),
    .ADDRW (ADDRW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign ready_in  = ready_in_q;
  assign valid_out = valid_out_q;
  assign count     = count_q;
  assign alm_full  = alm_full_q;

endmodule

// File: tb/tb_vx_stream_fifo.sv
// tb/tb_vx_stream_fifo.sv - self-checking bench for vx_stream_fifo
// Directed vector table, hand sequences, then random traffic against a queue model.
module tb_vx_stream_fifo;

  localparam int DATAW    = 8;
  localparam int DEPTH    = 4;
  localparam int ALM_FULL = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic             ready_in;
  logic [DATAW-1:0] data_in;
  logic             valid_out;
  logic             ready_out;
  logic [DATAW-1:0] data_out;
  logic [2:0]       count;
  logic             alm_full;

  int checks = 0;
  int errors = 0;

  vx_stream_fifo #(
    .DATAW    (DATAW),
    .DEPTH    (DEPTH),
    .ALM_FULL (ALM_FULL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .count     (count),
    .alm_full  (alm_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vi;
    logic [7:0] din;
    logic       ro;
    logic       e_vo;
    logic       e_ri;
    int         e_cnt;
    logic       e_af;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vecs [12];
  logic [7:0] model_q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic vi, input logic [7:0] d, input logic ro);
    valid_in  = vi;
    data_in   = d;
    ready_out = ro;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic vo, input logic ri,
                             input int cnt, input logic af);
    check({tag, " valid_out"}, int'(valid_out), int'(vo));
    check({tag, " ready_in"},  int'(ready_in),  int'(ri));
    check({tag, " count"},     int'(count),     cnt);
    check({tag, " alm_full"},  int'(alm_full),  int'(af));
  endtask

  initial begin
    //            vi  din    ro   vo   ri   cnt af   dout
    vecs[0]  = '{1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 1, 1'b0, 8'h0A};
    vecs[1]  = '{1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, 2, 1'b0, 8'h0A};
    vecs[2]  = '{1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 3, 1'b1, 8'h0A};
    vecs[3]  = '{1'b1, 8'h0D, 1'b0, 1'b1, 1'b0, 4, 1'b1, 8'h0A};
    vecs[4]  = '{1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 4, 1'b1, 8'h0A};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3, 1'b1, 8'h0B};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2, 1'b0, 8'h0C};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 8'h0D};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1, 1'b0, 8'h11};
    vecs[10] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1, 1'b0, 8'h22};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'h00};

    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
    #1;
    check_state("reset", 1'b0, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    check_state("reset_edge", 1'b0, 1'b1, 0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].vi, vecs[i].din, vecs[i].ro);
      check_state($sformatf("vec%0d", i), vecs[i].e_vo, vecs[i].e_ri,
                  vecs[i].e_cnt, vecs[i].e_af);
      if (vecs[i].e_vo)
        check($sformatf("vec%0d data_out", i), int'(data_out), int'(vecs[i].e_dout));
    end

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i), 1'b1);
      check($sformatf("stream%0d data_out", i), int'(data_out), i);
      check($sformatf("stream%0d count", i), int'(count), 1);
      check($sformatf("stream%0d valid_out", i), int'(valid_out), 1);
    end
    step(1'b0, 8'h00, 1'b1);
    check_state("stream_drain", 1'b0, 1'b1, 0, 1'b0);

    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    check_state("pre_reset", 1'b1, 1'b1, 3, 1'b1);
    #3 reset = 1'b1;
    #1;
    check_state("async_reset", 1'b0, 1'b1, 0, 1'b0);
    valid_in = 1'b1; data_in = 8'h77; ready_out = 1'b1;
    @(posedge clk); #1;
    check_state("held_reset", 1'b0, 1'b1, 0, 1'b0);
    reset = 1'b0;
    step(1'b1, 8'h55, 1'b0);
    check_state("post_reset_push", 1'b1, 1'b1, 1, 1'b0);
    check("post_reset data_out", int'(data_out), 8'h55);
    step(1'b0, 8'h00, 1'b1);
    check_state("post_reset_pop", 1'b0, 1'b1, 0, 1'b0);

    model_q.delete();
    for (int n = 0; n < 10000; n++) begin
      logic       vi, ro, m_push, m_pop;
      logic [7:0] d;
      int         sz;
      sz = model_q.size();
      check("rnd ready_in",  int'(ready_in),  int'(sz < DEPTH));
      check("rnd valid_out", int'(valid_out), int'(sz > 0));
      check("rnd count",     int'(count),     sz);
      check("rnd alm_full",  int'(alm_full),  int'(sz >= ALM_FULL));
      if (sz > 0) check("rnd data_out", int'(data_out), int'(model_q[0]));
      vi = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      m_push = vi && (sz < DEPTH);
      m_pop  = ro && (sz > 0);
      step(vi, d, ro);
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
